// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a
// pending-write scoreboard.
// - x0 is hardwired to zero.
// - Write ports are prioritised: a higher index wins on an address conflict.
// - Reads are combinational.
// - The busy bits plus a counter let the issue stage stall on in-flight
//   long-latency writebacks.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, each read
// port forwards same-cycle write data.
//
// Handshake (reservation port): a reservation transfers on a posedge where
// rsv_valid && rsv_ready. rsv_ready is a combinational function of rsv_addr,
// the busy bits and this cycle's writes. It never depends on rsv_valid. A
// requester seeing rsv_ready = 0 holds rsv_addr and retries; nothing changes
// in the meantime.
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  output logic [NREGS-1:0]     busy_vec,
  output logic [AW:0]          pending_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_pending;

  logic [NREGS-1:0] w_wr_hit;
  logic [NREGS-1:0] w_busy_set;
  logic [NREGS-1:0] w_busy_next;
  logic             w_rsv_accept;
  logic [AW:0]      w_set_cnt;
  logic [AW:0]      w_clr_cnt;

  // Decode which registers are written this cycle. x0 is never a real target.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < NWR; i++) begin
      if (we[i]) w_wr_hit[waddr[i*AW +: AW]] = 1'b1;
    end
    w_wr_hit[0] = 1'b0;
  end

  // Reservation handshake.
  // - A pending register blocks a second reservation (WAW), unless it is
  //   being written back this very cycle.
  // - x0 is always accepted, but it reserves nothing.
  always_comb begin
    rsv_ready    = (rsv_addr == '0) || !r_busy[rsv_addr] || w_wr_hit[rsv_addr];
    w_rsv_accept = rsv_valid && rsv_ready && (rsv_addr != '0);
    w_busy_set   = '0;
    if (w_rsv_accept) w_busy_set[rsv_addr] = 1'b1;
  end

  // Next scoreboard state.
  // - A write clears its target's busy bit.
  // - A reservation to the same register in the same cycle wins, so the bit
  //   stays set.
  // The counter moves by the bits that actually change, so it always tracks
  // the popcount of the busy bits.
  always_comb begin
    w_busy_next    = (r_busy & ~w_wr_hit) | w_busy_set;
    w_busy_next[0] = 1'b0;
    w_set_cnt      = '0;
    w_clr_cnt      = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_set_cnt = w_set_cnt + (AW+1)'(w_busy_next[k] & ~r_busy[k]);
      w_clr_cnt = w_clr_cnt + (AW+1)'(r_busy[k] & ~w_busy_next[k]);
    end
  end

  // Register storage. Later (higher-index) ports overwrite earlier ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (waddr[i*AW +: AW] != '0)) begin
          r_regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard state: busy bits and the pending-write counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_pending <= r_pending + w_set_cnt - w_clr_cnt;
    end
  end

  // Read ports: stored value (x0 forced to zero), optionally overridden by a
  // same-cycle write from the highest-index matching port.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (raddr[p*AW +: AW] != '0) begin
        rdata[p*XLEN +: XLEN] = r_regs[raddr[p*AW +: AW]];
      end
      rbusy[p] = r_busy[raddr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == raddr[p*AW +: AW]) &&
            (raddr[p*AW +: AW] != '0)) begin
          rdata[p*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          rbusy[p]              = 1'b0;
        end
      end
`endif
    end
  end

  assign busy_vec    = r_busy;
  assign pending_cnt = r_pending;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a
// behavioural register-file model. Honours REGFILE_BYPASS_EN like the design.
module tb_regfile_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic [NREGS-1:0]    busy_vec;
  logic [AW:0]         pending_cnt;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rsv_valid(rsv_valid),
    .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .busy_vec(busy_vec),
    .pending_cnt(pending_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];

  function automatic bit m_wr_hits(input int a);
    bit h = 1'b0;
    for (int j = 0; j < NWR; j++)
      if (we[j] && int'(waddr[j*AW +: AW]) == a) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_ready();
    int a = int'(rsv_addr);
    return (a == 0) || !m_busy[a] || m_wr_hits(a);
  endfunction

  function automatic logic [XLEN-1:0] m_rdata(input int p);
    int a = int'(raddr[p*AW +: AW]);
    logic [XLEN-1:0] v = (a == 0) ? '0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (a != 0 && we[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic bit m_rbusy(input int p);
    int a = int'(raddr[p*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
    return m_busy[a] && !(a != 0 && m_wr_hits(a));
`else
    return m_busy[a];
`endif
  endfunction

  function automatic logic [NREGS-1:0] m_busy_vec();
    logic [NREGS-1:0] v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i]) begin
          if (waddr[i*AW +: AW] != '0) m_mem[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
          m_busy[waddr[i*AW +: AW]] <= 1'b0;
        end
      end
      if (rsv_valid && m_ready() && rsv_addr != '0) m_busy[rsv_addr] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %0s: got 0x%0h expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], m_rdata(p));
        check($sformatf("rbusy%0d", p), 64'(rbusy[p]), 64'(m_rbusy(p)));
      end
      check("rsv_ready", 64'(rsv_ready), 64'(m_ready()));
      check("busy_vec", 64'(busy_vec), 64'(m_busy_vec()));
      check("pending_cnt", 64'(pending_cnt), 64'(m_pending()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic set_wr(input int port, input int addr, input logic [XLEN-1:0] d);
    we[port]                 = 1'b1;
    waddr[port*AW +: AW]     = AW'(addr);
    wdata[port*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int port, input int addr);
    raddr[port*AW +: AW] = AW'(addr);
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS-1))
                                       : int'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle();
    for (int i = 0; i < NWR; i++) begin
      we[i]                 = ($urandom_range(0, 2) == 0);
      waddr[i*AW +: AW]     = AW'(rand_addr());
      wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
    end
    for (int p = 0; p < NRD; p++) raddr[p*AW +: AW] = AW'(rand_addr());
    rsv_valid = ($urandom_range(0, 1) == 1);
    rsv_addr  = AW'(rand_addr());
    tick();
  endtask

  task automatic release_reset();
    idle();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    waddr = '0; wdata = '0; raddr = '0; rsv_addr = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    reset  = 1'b1;

    // Fill with random contents, then reset mid-operation.
    repeat (60) rand_cycle();
    idle();
    reset = 1'b0;
    #1;
    set_rd(0, 31); set_rd(1, 5);
    #1;
    check("rst_x31", rdata[0 +: XLEN], 64'h0);
    check("rst_x5", rdata[XLEN +: XLEN], 64'h0);
    check("rst_busy_vec", 64'(busy_vec), 64'h0);
    check("rst_pending", 64'(pending_cnt), 64'h0);
    check("rst_rsv_ready", 64'(rsv_ready), 64'h1);
    release_reset();

    // x0 ignores writes; ordinary write becomes visible next cycle.
    set_wr(0, 0, 64'hDEAD); set_rd(0, 0);
    tick(); idle(); #1;
    check("x0_write", rdata[0 +: XLEN], 64'h0);
    set_wr(0, 5, 64'h1234);
    tick(); idle(); set_rd(0, 5); #1;
    check("x5_write", rdata[0 +: XLEN], 64'h1234);

    // Same-address conflict: port 1 wins.
    set_wr(0, 7, 64'h1); set_wr(1, 7, 64'h2);
    tick(); idle(); set_rd(1, 7); #1;
    check("x7_conflict", rdata[XLEN +: XLEN], 64'h2);

    // Reserve x9, block the second reservation, clear by writeback.
    rsv_valid = 1'b1; rsv_addr = 5'd9; #1;
    check("rsv9_ready", 64'(rsv_ready), 64'h1);
    tick(); idle(); set_rd(0, 9); #1;
    check("busy9_set", 64'(busy_vec[9]), 64'h1);
    check("pend_after_rsv9", 64'(pending_cnt), 64'h1);
    check("rbusy_x9", 64'(rbusy[0]), 64'h1);
    rsv_valid = 1'b1; rsv_addr = 5'd9; #1;
    check("rsv9_again_ready", 64'(rsv_ready), 64'h0);
    tick(); #1;
    check("pend_held", 64'(pending_cnt), 64'h1);
    rsv_valid = 1'b0;
    set_wr(0, 9, 64'hAA);
    tick(); idle(); #1;
    check("busy9_clr", 64'(busy_vec[9]), 64'h0);
    check("pend_after_wr9", 64'(pending_cnt), 64'h0);
    check("x9_value", rdata[0 +: XLEN], 64'hAA);

    // Reserve and write x3 in the same cycle: set wins.
    rsv_valid = 1'b1; rsv_addr = 5'd3; set_wr(0, 3, 64'h77);
    tick(); idle(); #1;
    check("busy3_set_wins", 64'(busy_vec[3]), 64'h1);
    check("pend_x3", 64'(pending_cnt), 64'h1);
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    tick(); idle(); #1;
    check("pend_x3_x4", 64'(pending_cnt), 64'h2);
    #1 reset = 1'b0;
    #1;
    check("async_busy_vec", 64'(busy_vec), 64'h0);
    check("async_pending", 64'(pending_cnt), 64'h0);
    release_reset();

    // Write while reading a busy register: forwarding behaviour.
    set_wr(0, 12, 64'h55);
    tick(); idle();
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    tick(); idle();
    set_wr(0, 12, 64'hBEEF); set_rd(0, 12); #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rdata", rdata[0 +: XLEN], 64'hBEEF);
    check("bypass_rbusy", 64'(rbusy[0]), 64'h0);
`else
    check("nobypass_rdata", rdata[0 +: XLEN], 64'h55);
    check("nobypass_rbusy", 64'(rbusy[0]), 64'h1);
`endif
    tick(); idle(); #1;
    check("x12_after", rdata[0 +: XLEN], 64'hBEEF);
    check("busy12_clr", 64'(busy_vec[12]), 64'h0);

    // Randomized traffic with occasional reset pulses.
    for (int k = 0; k < 2000; k++) begin
      if (k % 400 == 399) begin
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
      end else begin
        rand_cycle();
      end
    end
    idle();
    repeat (3) tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
